// File: rtl/legv8_instr_encoder.sv
`default_nettype none
//==============================================================================
// Module      : legv8_instr_encoder
// Description : Packs decoded LEGv8 instruction fields (op class, registers,
//               immediate) received on a valid/ready stream into 32-bit
//               machine words and writes them sequentially into instruction
//               memory starting at a programmable base address.
// Config      : LEGV8_ENC_RANGE_CHECK_EN - when defined, immediates outside
//               their field range are rejected (err set, no write); when not
//               defined they are silently truncated.
// Revision    : 1.0 - initial release
//==============================================================================
module legv8_instr_encoder #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rn,
   input  logic [4:0]        in_rm,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              done,
   output logic              err,
   output logic              wrapped
);

   localparam logic [3:0] c_op_ldur = 4'd0;
   localparam logic [3:0] c_op_stur = 4'd1;
   localparam logic [3:0] c_op_add  = 4'd2;
   localparam logic [3:0] c_op_sub  = 4'd3;
   localparam logic [3:0] c_op_and  = 4'd4;
   localparam logic [3:0] c_op_orr  = 4'd5;
   localparam logic [3:0] c_op_addi = 4'd6;
   localparam logic [3:0] c_op_cbz  = 4'd7;
   localparam logic [3:0] c_op_cbnz = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] w_enc;
   logic        w_op_legal;
   logic        w_imm_ok;
   logic        w_accept;
   logic        w_complete;
   logic        w_write;
   logic        w_unused;

   // Immediate bits above the widest field only matter to the range check.
   assign w_unused = ^in_imm[31:19];

   // Pack the incoming fields into a machine word according to the op class.
   always_comb begin
      w_enc      = 32'd0;
      w_op_legal = 1'b1;
      case (in_op)
         c_op_ldur: w_enc = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
         c_op_stur: w_enc = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
         c_op_add:  w_enc = {11'b10001011000, in_rm, 6'd0, in_rn, in_rd};
         c_op_sub:  w_enc = {11'b11001011000, in_rm, 6'd0, in_rn, in_rd};
         c_op_and:  w_enc = {11'b10001010000, in_rm, 6'd0, in_rn, in_rd};
         c_op_orr:  w_enc = {11'b10101010000, in_rm, 6'd0, in_rn, in_rd};
         c_op_addi: w_enc = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
         c_op_cbz:  w_enc = {8'b10110100, in_imm[18:0], in_rd};
         c_op_cbnz: w_enc = {8'b10110101, in_imm[18:0], in_rd};
         default:   w_op_legal = 1'b0;
      endcase
   end

   // Decide whether the immediate fits its field (always true when truncating).
   always_comb begin
      w_imm_ok = 1'b1;
`ifdef LEGV8_ENC_RANGE_CHECK_EN
      case (in_op)
         c_op_addi:            w_imm_ok = ~|in_imm[31:12];
         c_op_ldur, c_op_stur: w_imm_ok = (&in_imm[31:8]) | (~|in_imm[31:8]);
         c_op_cbz, c_op_cbnz:  w_imm_ok = (&in_imm[31:18]) | (~|in_imm[31:18]);
         default:              w_imm_ok = 1'b1;
      endcase
`else
      w_imm_ok = 1'b1;
`endif
   end

   assign w_accept   = in_valid && in_ready;
   assign w_complete = wr_en && wr_ready;
   assign w_write    = w_accept && w_op_legal && w_imm_ok;

   // State register; reset aborts any load in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic plus the handshake and completion strobes.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            in_ready = !wr_en || wr_ready;
            if (in_valid && in_ready && in_last) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!wr_en) begin
               done        = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output register, address counter and sticky status flags.
   // wr_addr doubles as the write counter: it advances only when a write
   // completes, so a word accepted in the same cycle lands at the next address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= 32'd0;
         err     <= 1'b0;
         wrapped <= 1'b0;
      end else if (r_state == ST_IDLE && start) begin
         wr_addr <= base_addr;
         err     <= 1'b0;
         wrapped <= 1'b0;
      end else begin
         if (w_complete) begin
            wr_addr <= wr_addr + 1'b1;
            if (&wr_addr) begin
               wrapped <= 1'b1;
            end
         end
         if (w_write) begin
            wr_data <= w_enc;
         end else if (w_accept) begin
            err <= 1'b1;
         end
         wr_en <= (wr_en && !wr_ready) || w_write;
      end
   end

endmodule
`default_nettype wire
